// File: rtl/aes256_round_key_feeder.sv
// AES-256 key schedule plus forward/reverse round-key-pair sequencer for the block engine.
// Latency: key expansion takes 14 cycles to outKeyReady; the step-0 pair is combinational in the inStart cycle, then one pair per cycle.
// No backpressure: starts outside READY, or before the last step, are dropped; key writes during RUN are ignored.
module aes256_round_key_feeder #(
  parameter int NUM_STEPS = 14
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inKeyWr,
  input  logic [255:0] inKeyWrData,
  input  logic         inAesMode,
  input  logic         inStart,
  output logic [255:0] outKeyData,
  output logic         outKeyReady,
  output logic         outBusy
);

  localparam logic [1:0] sIdle   = 2'd0;
  localparam logic [1:0] sExpand = 2'd1;
  localparam logic [1:0] sReady  = 2'd2;
  localparam logic [1:0] sRun    = 2'd3;
  localparam logic [3:0] lastStep = 4'(NUM_STEPS - 1);

  logic [1:0]   state;
  logic [3:0]   expIdx;
  logic [3:0]   stepCnt;
  logic         runMode;
  logic [127:0] rk [0:14];

  // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gfMul(gfMul(a, a), a);
    x7   = gfMul(gfMul(x3, x3), a);
    x15  = gfMul(gfMul(x7, x7), a);
    x31  = gfMul(gfMul(x15, x15), a);
    x63  = gfMul(gfMul(x31, x31), a);
    x127 = gfMul(gfMul(x63, x63), a);
    inv  = gfMul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [3:0]   idxM1, idxM2;
  logic [127:0] prevKey;
  logic [31:0]  lastWord;
  logic [31:0]  subIn;
  logic [7:0]   rcon;
  logic [31:0]  temp;
  logic [31:0]  nw0, nw1, nw2, nw3;

  // Next round key rk[expIdx] from rk[expIdx-2] and the last word of rk[expIdx-1]
  always_comb begin
    idxM1    = expIdx - 4'd1;
    idxM2    = expIdx - 4'd2;
    prevKey  = rk[idxM2];
    lastWord = rk[idxM1][31:0];
    subIn    = expIdx[0] ? lastWord : {lastWord[23:0], lastWord[31:24]};
    rcon     = expIdx[0] ? 8'h00 : (8'h01 << (expIdx[3:1] - 3'd1));
    temp     = subWord(subIn) ^ {rcon, 24'h0};
    nw0      = prevKey[127:96] ^ temp;
    nw1      = prevKey[95:64]  ^ nw0;
    nw2      = prevKey[63:32]  ^ nw1;
    nw3      = prevKey[31:0]   ^ nw2;
  end

  // Round-key storage: cipher key halves on an accepted key write, one expanded key per EXPAND cycle
  always_ff @(posedge inClk) begin
    if (inKeyWr && state != sRun) begin
      rk[0] <= inKeyWrData[255:128];
      rk[1] <= inKeyWrData[127:0];
    end else if (state == sExpand) begin
      rk[expIdx] <= {nw0, nw1, nw2, nw3};
    end
  end

  // Control FSM: expansion progress, block step counter and latched direction
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state   <= sIdle;
      expIdx  <= 4'd0;
      stepCnt <= 4'd0;
      runMode <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          if (inKeyWr) begin
            state  <= sExpand;
            expIdx <= 4'd2;
          end
        end
        sExpand: begin
          if (inKeyWr) expIdx <= 4'd2;
          else if (expIdx == 4'd14) state <= sReady;
          else expIdx <= expIdx + 4'd1;
        end
        sReady: begin
          if (inKeyWr) begin
            state  <= sExpand;
            expIdx <= 4'd2;
          end else if (inStart) begin
            state   <= sRun;
            stepCnt <= 4'd1;
            runMode <= inAesMode;
          end
        end
        default: begin
          if (stepCnt == lastStep) begin
            stepCnt <= 4'd0;
            if (inStart) runMode <= inAesMode;
            else state <= sReady;
          end else begin
            stepCnt <= stepCnt + 4'd1;
          end
        end
      endcase
    end
  end

  logic       selMode;
  logic [3:0] selStep;
  logic [3:0] idx0, idx1;

  // Key pair for the current step; READY previews step 0 for the live mode
  always_comb begin
    selMode    = (state == sRun) ? runMode : inAesMode;
    selStep    = (state == sRun) ? stepCnt : 4'd0;
    idx0       = selMode ? selStep : 4'd14 - selStep;
    idx1       = selMode ? selStep + 4'd1 : 4'd13 - selStep;
    outKeyData = '0;
    if (state == sReady || state == sRun) outKeyData = {rk[idx1], rk[idx0]};
  end

  assign outKeyReady = (state == sReady) || (state == sRun);
  assign outBusy     = (state == sRun);

endmodule
